// File: rtl/parity21_pkg.sv
// Shared widths and burst-alarm state encoding for the 21-bit parity checker.
package parity21_pkg;
    localparam int DATA_W = 20;
    localparam int CODE_W = 21;
    localparam int RUN_W  = 8;

    typedef enum logic [1:0] {
        ST_GOOD    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_ALARM   = 2'd2
    } burst_state_t;
endpackage

// File: rtl/parity21_tree.sv
// Combinational 21-bit XOR reduction; err is high when the word's parity
// disagrees with the selected sense (ODD=0 even, ODD=1 odd).
module parity21_tree
    import parity21_pkg::*;
#(
    parameter bit ODD = 1'b0
) (
    input  logic [CODE_W-1:0] code,
    output logic              err
);
    assign err = (^code) ^ ODD;
endmodule

// File: rtl/parity21_checker.sv
// Receive-side parity checker with one-deep output register, sticky error and
// burst alarm. Define PARITY21_ERRCNT_EN to add the saturating ERRCNT counter.
module parity21_checker
    import parity21_pkg::*;
#(
    parameter bit          ODD   = 1'b0,
    parameter int unsigned BURST = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic [CODE_W-1:0] DIN,
    input  logic              DVAL,
    output logic              DRDY,
    output logic [DATA_W-1:0] DOUT,
    output logic              PERR,
    output logic              OVAL,
    input  logic              ORDY,
    input  logic              CLR,
    output logic              STICKY,
    output logic              ALARM
`ifdef PARITY21_ERRCNT_EN
    ,
    output logic [CNTW-1:0]   ERRCNT
`endif
);
    localparam logic [RUN_W-1:0] BURST_CNT = RUN_W'(BURST);

    logic              word_err;
    logic              accept;
    logic              oval_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              perr_reg;
    logic              sticky_reg;
    logic              sticky_next;
    burst_state_t      state_reg;
    burst_state_t      state_next;
    burst_state_t      state_base;
    logic [RUN_W-1:0]  run_reg;
    logic [RUN_W-1:0]  run_next;
    logic [RUN_W-1:0]  run_base;

    parity21_tree #(.ODD(ODD)) u_tree (
        .code(DIN),
        .err (word_err)
    );

    assign DRDY   = !oval_reg || ORDY;
    assign accept = DVAL && DRDY;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            oval_reg <= 1'b0;
            dout_reg <= '0;
            perr_reg <= 1'b0;
        end else if (accept) begin
            oval_reg <= 1'b1;
            dout_reg <= DIN[DATA_W-1:0];
            perr_reg <= word_err;
        end else if (ORDY) begin
            oval_reg <= 1'b0;
        end
    end

    // CLR is folded in before the accepted word so a coincident error still counts.
    always_comb begin
        state_base  = CLR ? ST_GOOD : state_reg;
        run_base    = CLR ? '0 : run_reg;
        state_next  = state_base;
        run_next    = run_base;
        sticky_next = (CLR ? 1'b0 : sticky_reg) | (accept && word_err);
        if (accept) begin
            case (state_base)
                ST_GOOD: begin
                    if (word_err) begin
                        state_next = ST_SUSPECT;
                        run_next   = RUN_W'(1);
                    end
                end
                ST_SUSPECT: begin
                    if (word_err) begin
                        run_next = run_base + 1'b1;
                        if (run_base + 1'b1 == BURST_CNT) begin
                            state_next = ST_ALARM;
                        end
                    end else begin
                        state_next = ST_GOOD;
                        run_next   = '0;
                    end
                end
                ST_ALARM: begin
                    state_next = ST_ALARM;
                end
                default: begin
                    state_next = ST_GOOD;
                    run_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg  <= ST_GOOD;
            run_reg    <= '0;
            sticky_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            run_reg    <= run_next;
            sticky_reg <= sticky_next;
        end
    end

`ifdef PARITY21_ERRCNT_EN
    logic [CNTW-1:0] errcnt_reg;
    logic [CNTW-1:0] errcnt_next;
    logic [CNTW-1:0] errcnt_base;

    always_comb begin
        errcnt_base = CLR ? '0 : errcnt_reg;
        errcnt_next = errcnt_base;
        if (accept && word_err && (errcnt_base != '1)) begin
            errcnt_next = errcnt_base + 1'b1;
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            errcnt_reg <= '0;
        end else begin
            errcnt_reg <= errcnt_next;
        end
    end

    assign ERRCNT = errcnt_reg;
`endif

    assign OVAL   = oval_reg;
    assign DOUT   = dout_reg;
    assign PERR   = perr_reg;
    assign STICKY = sticky_reg;
    assign ALARM  = (state_reg == ST_ALARM);
endmodule

// File: tb/tb_parity21_checker.sv
// Directed bench for parity21_checker: scoreboarded data path plus sticky,
// burst alarm, clear, counter and asynchronous reset checks.
module tb_parity21_checker;
    localparam bit ODD = 1'b0;
    localparam logic [20:0] BAD  = 21'h000007;
    localparam logic [20:0] GOOD = 21'h000003;

    logic        ck = 1'b0;
    logic        rstn;
    logic [20:0] din;
    logic        dval;
    logic        drdy;
    logic [19:0] dout;
    logic        perr;
    logic        oval;
    logic        ordy;
    logic        clr;
    logic        sticky;
    logic        alarm;
`ifdef PARITY21_ERRCNT_EN
    logic [1:0]  errcnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];

    always #5 ck = ~ck;

    parity21_checker #(.ODD(ODD), .BURST(4), .CNTW(2)) dut (
        .CK    (ck),
        .RSTN  (rstn),
        .DIN   (din),
        .DVAL  (dval),
        .DRDY  (drdy),
        .DOUT  (dout),
        .PERR  (perr),
        .OVAL  (oval),
        .ORDY  (ordy),
        .CLR   (clr),
        .STICKY(sticky),
        .ALARM (alarm)
`ifdef PARITY21_ERRCNT_EN
        ,
        .ERRCNT(errcnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input logic [20:0] w);
        return (($countones(w) % 2) == 1) != ODD;
    endfunction

    // One clock: pop/compare a word leaving the DUT, push a word entering it.
    task automatic cycle();
        logic [20:0] e;
        #1;
        if (oval && ordy) begin
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_dout", 32'(dout), 32'(e[19:0]));
                chk("sb_perr", 32'(perr), 32'(e[20]));
            end
        end
        if (dval && drdy) exp_q.push_back({exp_err(din), din[19:0]});
        @(posedge ck);
        #1;
    endtask

    task automatic send(input logic [20:0] w);
        din  = w;
        dval = 1'b1;
        cycle();
        dval = 1'b0;
    endtask

    task automatic idle();
        dval = 1'b0;
        cycle();
    endtask

    initial begin
        rstn = 1'b0;
        din  = '0;
        dval = 1'b0;
        ordy = 1'b1;
        clr  = 1'b0;
        #2;
        chk("rst_oval", oval, 0);
        chk("rst_dout", dout, 0);
        chk("rst_perr", perr, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_drdy", drdy, 1);
        repeat (2) @(posedge ck);
        #1;
        rstn = 1'b1;

        // Odd-weight word under even parity, then an even-weight one
        send(21'h000001);
        chk("w1_oval", oval, 1);
        chk("w1_dout", dout, 20'h00001);
        chk("w1_perr", perr, 1);
        chk("w1_sticky", sticky, 1);
        send(21'h100001);
        chk("w2_dout", dout, 20'h00001);
        chk("w2_perr", perr, 0);
        chk("w2_sticky", sticky, 1);
        idle();
        chk("drain_oval", oval, 0);
        clr = 1'b1;
        idle();
        clr = 1'b0;
        chk("clr_sticky", sticky, 0);

        // Back-pressure: held word must stay put, then streaming resumes
        ordy = 1'b0;
        send(21'h0ABCDE);
        chk("stall_oval", oval, 1);
        din  = 21'h012345;
        dval = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_drdy", drdy, 0);
            chk("stall_dout", dout, 20'hABCDE);
        end
        ordy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(21'((i * 32'h2F1B3) + 32'h15));
            chk("stream_oval", oval, 1);
        end
        idle();
        idle();
        chk("stream_drained", exp_q.size(), 0);

        // Burst alarm
        clr = 1'b1;
        idle();
        clr = 1'b0;
        chk("pre_burst_alarm", alarm, 0);
        chk("pre_burst_sticky", sticky, 0);
        repeat (3) send(BAD);
        send(GOOD);
        chk("run_broken_alarm", alarm, 0);
        send(BAD);
        send(BAD);
        idle();
        send(BAD);
        chk("burst3_alarm", alarm, 0);
        send(BAD);
        chk("burst4_alarm", alarm, 1);
        for (int i = 0; i < 10; i++) begin
            send(GOOD);
            chk("alarm_hold", alarm, 1);
        end
        clr = 1'b1;
        idle();
        clr = 1'b0;
        chk("clr_alarm", alarm, 0);
        chk("clr_sticky2", sticky, 0);

        // CLR coincident with an accepted bad word restarts the run at 1
        send(BAD);
        clr = 1'b1;
        send(BAD);
        clr = 1'b0;
        chk("coinc_sticky", sticky, 1);
        chk("coinc_alarm", alarm, 0);
`ifdef PARITY21_ERRCNT_EN
        chk("coinc_errcnt", errcnt, 1);
`endif
        send(BAD);
        send(BAD);
        chk("coinc_run3_alarm", alarm, 0);
        send(BAD);
        chk("coinc_run4_alarm", alarm, 1);
`ifdef PARITY21_ERRCNT_EN
        clr = 1'b1;
        idle();
        clr = 1'b0;
        chk("cnt_cleared", errcnt, 0);
        for (int i = 0; i < 5; i++) begin
            send(BAD);
            chk("cnt_sat", errcnt, (i < 3) ? i + 1 : 3);
        end
`endif

        // Asynchronous reset with a held word and a run in progress
        clr = 1'b1;
        idle();
        clr = 1'b0;
        ordy = 1'b0;
        send(BAD);
        chk("prerst_oval", oval, 1);
        chk("prerst_sticky", sticky, 1);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_oval", oval, 0);
        chk("arst_dout", dout, 0);
        chk("arst_perr", perr, 0);
        chk("arst_sticky", sticky, 0);
        chk("arst_alarm", alarm, 0);
        chk("arst_drdy", drdy, 1);
`ifdef PARITY21_ERRCNT_EN
        chk("arst_errcnt", errcnt, 0);
`endif
        exp_q.delete();
        @(posedge ck);
        #1;
        rstn = 1'b1;
        ordy = 1'b1;
        send(21'h0F0F0F);
        repeat (3) send(BAD);
        chk("postrst_run3_alarm", alarm, 0);
        send(BAD);
        chk("postrst_run4_alarm", alarm, 1);
        idle();
        idle();
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
